// File: rtl/mem_stage_module.sv
// mem_stage_module: ARM MEM stage with a wait-stated SRAM model and the MEM/WB register.
// Optional macro MEM_FWD_EN drives mem_wb_val from alu_res_in; otherwise mem_wb_val is 0.
module mem_stage_module #(
  parameter int          MEM_DEPTH   = 64,
  parameter int          WAIT_CYCLES = 3,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_en_in,
  input  logic        mem_r_en_in,
  input  logic        mem_w_en_in,
  input  logic [31:0] alu_res_in,
  input  logic [31:0] val_r_m_in,
  input  logic [3:0]  dest_in,
  output logic        wb_en_out,
  output logic        mem_r_en_out,
  output logic [31:0] alu_res_out,
  output logic [31:0] mem_data_out,
  output logic [3:0]  dest_out,
  output logic        ready,
  output logic [31:0] mem_wb_val
);
  localparam int AW = $clog2(MEM_DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t        r_state;
  logic [3:0]    r_cnt;
  logic [31:0]   r_mem [MEM_DEPTH];
  logic [AW-1:0] w_idx;
  logic          w_req;
  logic          w_done;
  assign w_req  = mem_r_en_in | mem_w_en_in;
  assign w_done = r_state == DONE;
  assign w_idx  = AW'((alu_res_in - BASE_ADDR) >> 2);
  assign ready  = w_done | (r_state == IDLE && !w_req);
`ifdef MEM_FWD_EN
  assign mem_wb_val = alu_res_in;
`else
  assign mem_wb_val = '0;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      wb_en_out    <= 1'b0;
      mem_r_en_out <= 1'b0;
      alu_res_out  <= '0;
      mem_data_out <= '0;
      dest_out     <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_req) begin
          r_state <= WAIT;
          r_cnt   <= 4'(WAIT_CYCLES - 1);
        end
        WAIT: if (r_cnt == 4'd0) r_state <= DONE;
              else r_cnt <= r_cnt - 4'd1;
        default: r_state <= IDLE;
      endcase
      // a stalled stage emits a bubble while keeping its data fields
      wb_en_out    <= ready & wb_en_in;
      mem_r_en_out <= ready & mem_r_en_in;
      if (ready) begin
        alu_res_out <= alu_res_in;
        dest_out    <= dest_in;
      end
      if (w_done && mem_r_en_in) mem_data_out <= mem_w_en_in ? '0 : r_mem[w_idx];
    end
  end
  // reset forces IDLE asynchronously, so an interrupted store never commits
  always_ff @(posedge clk)
    if (w_done && mem_w_en_in) r_mem[w_idx] <= val_r_m_in;
endmodule

// File: tb/tb_mem_stage_module.sv
// tb_mem_stage_module: directed self-checking bench for mem_stage_module (WAIT_CYCLES=3, MEM_DEPTH=64).
module tb_mem_stage_module;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_en_in = 1'b0, mem_r_en_in = 1'b0, mem_w_en_in = 1'b0;
  logic [31:0] alu_res_in = '0, val_r_m_in = '0;
  logic [3:0]  dest_in = '0;
  logic        wb_en_out, mem_r_en_out, ready;
  logic [31:0] alu_res_out, mem_data_out, mem_wb_val;
  logic [3:0]  dest_out;
  int checks = 0, failures = 0, cyc = 0, wb_cnt = 0;

  mem_stage_module dut (
    .clk(clk), .rst(rst), .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in),
    .mem_w_en_in(mem_w_en_in), .alu_res_in(alu_res_in), .val_r_m_in(val_r_m_in),
    .dest_in(dest_in), .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out),
    .alu_res_out(alu_res_out), .mem_data_out(mem_data_out), .dest_out(dest_out),
    .ready(ready), .mem_wb_val(mem_wb_val)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (wb_en_out === 1'b1) wb_cnt <= wb_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb_en_in = 0; mem_r_en_in = 0; mem_w_en_in = 0;
    alu_res_in = '0; val_r_m_in = '0; dest_in = '0;
  endtask

  // drives one access, waits through the stall, leaves time just after the DONE edge
  task automatic access(input logic wb, input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] ds, output int lows, output logic stall_ok);
    wb_en_in = wb; mem_r_en_in = r; mem_w_en_in = w;
    alu_res_in = a; val_r_m_in = d; dest_in = ds;
    lows = 0; stall_ok = 1'b1;
    #1;
    while (ready !== 1'b1 && lows < 20) begin
      lows++;
      tick();
      if (wb_en_out !== 1'b0) stall_ok = 1'b0;
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_reset();
    rst = 1; idle_inputs();
    tick(); tick();
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", ready); end
    checks++; if (alu_res_out !== 32'd0) begin failures++; $display("FAIL rst_alu got=%h exp=0", alu_res_out); end
    checks++; if (mem_data_out !== 32'd0) begin failures++; $display("FAIL rst_mdata got=%h exp=0", mem_data_out); end
    checks++; if ({wb_en_out, mem_r_en_out, dest_out} !== 6'd0) begin failures++; $display("FAIL rst_ctl got=%b exp=0", {wb_en_out, mem_r_en_out, dest_out}); end
    rst = 0;
    tick();
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL post_rst_ready got=%b exp=1", ready); end
  endtask

  task automatic test_reset_mid_store();
    int lows; logic ok;
    access(1'b0, 1'b0, 1'b1, 32'd1024, 32'hCAFEF00D, 4'd2, lows, ok);
    wb_en_in = 1; mem_w_en_in = 1; alu_res_in = 32'd1024; val_r_m_in = 32'hDEADBEEF; dest_in = 4'd6;
    tick(); tick();
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL midstore_ready got=%b exp=0", ready); end
    idle_inputs();
    rst = 1;
    #1;
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%b exp=1", ready); end
    checks++; if (alu_res_out !== 32'd0) begin failures++; $display("FAIL midrst_alu got=%h exp=0", alu_res_out); end
    checks++; if (dest_out !== 4'd0) begin failures++; $display("FAIL midrst_dest got=%h exp=0", dest_out); end
    tick();
    rst = 0;
    access(1'b1, 1'b1, 1'b0, 32'd1024, 32'd0, 4'd1, lows, ok);
    checks++; if (mem_data_out !== 32'hCAFEF00D) begin failures++; $display("FAIL discard_store got=%h exp=cafef00d", mem_data_out); end
  endtask

  task automatic test_store_load();
    int lows; logic ok;
    access(1'b0, 1'b0, 1'b1, 32'd1028, 32'h12345678, 4'd3, lows, ok);
    checks++; if (lows !== 4) begin failures++; $display("FAIL st_stall got=%0d exp=4", lows); end
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL st_bubble got=%b exp=1", ok); end
    checks++; if (wb_en_out !== 1'b0) begin failures++; $display("FAIL st_wb got=%b exp=0", wb_en_out); end
    access(1'b1, 1'b1, 1'b0, 32'd1028, 32'd0, 4'd9, lows, ok);
    checks++; if (lows !== 4) begin failures++; $display("FAIL ld_stall got=%0d exp=4", lows); end
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL ld_bubble got=%b exp=1", ok); end
    checks++; if (mem_data_out !== 32'h12345678) begin failures++; $display("FAIL ld_data got=%h exp=12345678", mem_data_out); end
    checks++; if ({wb_en_out, mem_r_en_out} !== 2'b11) begin failures++; $display("FAIL ld_ctl got=%b exp=11", {wb_en_out, mem_r_en_out}); end
    checks++; if (dest_out !== 4'd9) begin failures++; $display("FAIL ld_dest got=%0d exp=9", dest_out); end
    tick();
    checks++; if (wb_en_out !== 1'b0) begin failures++; $display("FAIL ld_single_wb got=%b exp=0", wb_en_out); end
  endtask

  task automatic test_passthrough();
    wb_en_in = 1; alu_res_in = 32'd7; dest_in = 4'd5;
    #1;
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL pass_ready got=%b exp=1", ready); end
    tick();
    checks++; if (alu_res_out !== 32'd7) begin failures++; $display("FAIL pass_alu got=%0d exp=7", alu_res_out); end
    checks++; if (dest_out !== 4'd5) begin failures++; $display("FAIL pass_dest got=%0d exp=5", dest_out); end
    checks++; if ({wb_en_out, mem_r_en_out} !== 2'b10) begin failures++; $display("FAIL pass_ctl got=%b exp=10", {wb_en_out, mem_r_en_out}); end
    checks++; if (mem_data_out !== 32'h12345678) begin failures++; $display("FAIL pass_mdata_hold got=%h exp=12345678", mem_data_out); end
    idle_inputs();
  endtask

  task automatic test_wrap();
    int lows; logic ok;
    access(1'b0, 1'b0, 1'b1, 32'd1280, 32'hA5A50F0F, 4'd0, lows, ok);
    access(1'b1, 1'b1, 1'b0, 32'd1024, 32'd0, 4'd4, lows, ok);
    checks++; if (mem_data_out !== 32'hA5A50F0F) begin failures++; $display("FAIL wrap_data got=%h exp=a5a50f0f", mem_data_out); end
  endtask

  task automatic test_back_to_back();
    int lows, c0, w0; logic ok;
    access(1'b0, 1'b0, 1'b1, 32'd1032, 32'h11112222, 4'd0, lows, ok);
    access(1'b0, 1'b0, 1'b1, 32'd1036, 32'h33334444, 4'd0, lows, ok);
    c0 = cyc; w0 = wb_cnt;
    access(1'b1, 1'b1, 1'b0, 32'd1032, 32'd0, 4'd7, lows, ok);
    checks++; if (mem_data_out !== 32'h11112222) begin failures++; $display("FAIL b2b_data1 got=%h exp=11112222", mem_data_out); end
    wb_en_in = 1; mem_r_en_in = 1; alu_res_in = 32'd1036; dest_in = 4'd8;
    #1;
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL b2b_restart got=%b exp=0", ready); end
    access(1'b1, 1'b1, 1'b0, 32'd1036, 32'd0, 4'd8, lows, ok);
    checks++; if (cyc - c0 !== 10) begin failures++; $display("FAIL b2b_cycles got=%0d exp=10", cyc - c0); end
    checks++; if (mem_data_out !== 32'h33334444) begin failures++; $display("FAIL b2b_data2 got=%h exp=33334444", mem_data_out); end
    tick();
    checks++; if (wb_cnt - w0 !== 2) begin failures++; $display("FAIL b2b_wb_count got=%0d exp=2", wb_cnt - w0); end
  endtask

  task automatic test_fwd();
    logic [31:0] exp;
`ifdef MEM_FWD_EN
    exp = 32'h55;
`else
    exp = 32'h0;
`endif
    alu_res_in = 32'h55;
    #1;
    checks++; if (mem_wb_val !== exp) begin failures++; $display("FAIL fwd_val got=%h exp=%h", mem_wb_val, exp); end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_reset_mid_store();
    test_store_load();
    test_passthrough();
    test_wrap();
    test_back_to_back();
    test_fwd();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
